// File: rtl/fb_fill_engine_pkg.sv
// fb_pkg: shared types and defaults for the framebuffer fill engine
// Contents: default visible size, command opcodes, command record, fill FSM states.
package fb_pkg;
  localparam int DEF_FB_W = 200;
  localparam int DEF_FB_H = 150;
  typedef enum logic [1:0] {
    OP_PIXEL = 2'b00,
    OP_RECT  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } fb_op_e;
  typedef struct packed {
    fb_op_e      op;
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  w;
    logic [8:0]  h;
    logic [23:0] color;
  } fb_cmd_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } fill_state_e;
endpackage

// File: rtl/fb_fill_engine_if.sv
// fb_fill_engine_if: command handshake and framebuffer write stream of the fill engine
// Command side: cmd_valid/cmd_ready, cmd_op, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color.
// Write side: fb_enable, xy_addr {y,x}, color; status: busy, done.
// master = command source / framebuffer sink, slave = the engine.
interface fb_fill_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        fb_enable;
  logic [15:0] xy_addr;
  logic [23:0] color;
  logic        busy;
  logic        done;
  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, fb_enable, xy_addr, color, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    output cmd_ready, fb_enable, xy_addr, color, busy, done
  );
endinterface

// File: rtl/fb_fill_engine_cmd_fifo.sv
// fb_cmd_fifo: synchronous command FIFO (DEPTH a power of two, at least 2)
// Ports: clk, reset_n (sync, active-low), push_i/data_i, pop_i/data_o (head, show-ahead),
// full_o, empty_o. Push is ignored when full, pop when empty.
module fb_cmd_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  fb_cmd_t data_i,
  output fb_cmd_t data_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(DEPTH);
  fb_cmd_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    full_o  = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    empty_o = wr_q == rd_q;
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    data_o  = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    wr_q <= !reset_n ? '0 : wr_d;
    rd_q <= !reset_n ? '0 : rd_d;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: clips PIXEL/RECT/CLEAR commands to the visible area and streams one framebuffer write per cycle
// Ports: clk, reset_n (sync, active-low), bus (fb_fill_engine_if.slave): command
// valid/ready handshake in, fb_enable/xy_addr/color write stream out, busy/done status.
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int FB_W       = DEF_FB_W,
  parameter int FB_H       = DEF_FB_H,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset_n,
  fb_fill_engine_if.slave bus
);
  localparam logic [9:0] W10 = 10'(FB_W);
  localparam logic [9:0] H10 = 10'(FB_H);
  fb_cmd_t push_cmd, head, cmd_q, cmd_d;
  fill_state_e state_q, state_d;
  logic full, empty, pop, last, off_screen, no_area;
  logic [7:0] x_q, x_d, y_q, y_d, xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
  logic [7:0] ld_xs, ld_ys, ld_xe, ld_ye;
  logic [23:0] color_q, color_d;
  logic [9:0] x_sum, y_sum, x_lim, y_lim;
  assign push_cmd = '{op: fb_op_e'(bus.cmd_op), x0: bus.cmd_x0, y0: bus.cmd_y0,
                      w: bus.cmd_w, h: bus.cmd_h, color: bus.cmd_color};
  fb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.cmd_valid && !full),
    .pop_i   (pop),
    .data_i  (push_cmd),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // Clipping uses 10-bit sums so x0 + w never wraps before the min().
  always_comb begin
    x_sum      = {2'b0, cmd_q.x0} + {1'b0, cmd_q.w};
    y_sum      = {2'b0, cmd_q.y0} + {1'b0, cmd_q.h};
    x_lim      = x_sum > W10 ? W10 : x_sum;
    y_lim      = y_sum > H10 ? H10 : y_sum;
    off_screen = {2'b0, cmd_q.x0} >= W10 || {2'b0, cmd_q.y0} >= H10;
    no_area    = cmd_q.op == OP_RSVD || (cmd_q.op != OP_CLEAR && off_screen) ||
                 (cmd_q.op == OP_RECT && (cmd_q.w == '0 || cmd_q.h == '0));
    ld_xs      = cmd_q.op == OP_CLEAR ? 8'd0 : cmd_q.x0;
    ld_ys      = cmd_q.op == OP_CLEAR ? 8'd0 : cmd_q.y0;
    ld_xe      = cmd_q.op == OP_CLEAR ? 8'(FB_W - 1) : cmd_q.op == OP_RECT ? 8'(x_lim - 10'd1) : cmd_q.x0;
    ld_ye      = cmd_q.op == OP_CLEAR ? 8'(FB_H - 1) : cmd_q.op == OP_RECT ? 8'(y_lim - 10'd1) : cmd_q.y0;
    last       = x_q == xe_q && y_q == ye_q;
  end
  always_ff @(posedge clk)
    state_q <= !reset_n ? S_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = empty ? S_IDLE : S_LOAD;
      S_LOAD:  state_d = no_area ? S_DONE : S_RUN;
      S_RUN:   state_d = last ? S_DONE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    pop           = state_q == S_IDLE && !empty;
    bus.cmd_ready = !full;
    bus.fb_enable = state_q == S_RUN;
    bus.done      = state_q == S_DONE;
    bus.busy      = state_q != S_IDLE || !empty;
    bus.xy_addr   = {y_q, x_q};
    bus.color     = color_q;
  end
  // Counters hold on the final write so xy_addr stays at the last address.
  always_comb begin
    cmd_d   = pop ? head : cmd_q;
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    color_d = color_q;
    if (state_q == S_LOAD) begin
      x_d     = ld_xs;
      y_d     = ld_ys;
      xs_d    = ld_xs;
      xe_d    = ld_xe;
      ye_d    = ld_ye;
      color_d = cmd_q.color;
    end else if (state_q == S_RUN && !last) begin
      x_d = x_q == xe_q ? xs_q : x_q + 8'd1;
      y_d = x_q == xe_q ? y_q + 8'd1 : y_q;
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      cmd_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      color_q <= '0;
    end else begin
      cmd_q   <= cmd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      color_q <= color_d;
    end
endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: directed table-driven bench for fb_fill_engine
module tb_fb_fill_engine;
  import fb_pkg::*;
  typedef struct {
    logic [1:0]  op;
    logic [7:0]  x0, y0;
    logic [8:0]  w, h;
    logic [23:0] col;
    int          n;
    logic [7:0]  xs, ys, xe, ye;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int dn = 0;
  logic [15:0] wq[$];
  vec_t tbl[12];
  always #5 clk = ~clk;
  fb_fill_engine_if bus();
  fb_fill_engine #(.FB_W(200), .FB_H(150), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always @(negedge clk)
    if (reset_n) begin
      if (bus.fb_enable) wq.push_back(bus.xy_addr);
      if (bus.done) dn++;
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                      input logic [8:0] w, input logic [8:0] h, input logic [23:0] col);
    int t = 0;
    bus.cmd_op = op;
    bus.cmd_x0 = x0;
    bus.cmd_y0 = y0;
    bus.cmd_w = w;
    bus.cmd_h = h;
    bus.cmd_color = col;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && t < 40000) begin
      tick;
      t++;
    end
    if (!bus.cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready stayed 0");
    end
    tick;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic run_vec(input int i, input vec_t v);
    int cyc = 1, n = 0, first_c = -1, last_c = -1, done_c = -1, aerr = 0, cerr = 0;
    int wd = int'(v.xe) - int'(v.xs) + 1;
    logic [15:0] first_a = '0, last_a = '0, exp_a;
    send(v.op, v.x0, v.y0, v.w, v.h, v.col);
    while (cyc < 31000) begin
      if (bus.fb_enable) begin
        exp_a = {8'(int'(v.ys) + n / wd), 8'(int'(v.xs) + n % wd)};
        if (bus.xy_addr !== exp_a) aerr++;
        if (bus.color !== v.col) cerr++;
        if (n == 0) begin
          first_c = cyc;
          first_a = bus.xy_addr;
        end
        last_c = cyc;
        last_a = bus.xy_addr;
        n++;
      end
      if (bus.done) begin
        done_c = cyc;
        break;
      end
      tick;
      cyc++;
    end
    check($sformatf("v%0d_writes", i), n, v.n);
    check($sformatf("v%0d_done_cycle", i), done_c, 3 + v.n);
    if (v.n > 0) begin
      check($sformatf("v%0d_first_cycle", i), first_c, 3);
      check($sformatf("v%0d_last_cycle", i), last_c, 2 + v.n);
      check($sformatf("v%0d_first_addr", i), first_a, {v.ys, v.xs});
      check($sformatf("v%0d_last_addr", i), last_a, {v.ye, v.xe});
      check($sformatf("v%0d_addr_errs", i), aerr, 0);
      check($sformatf("v%0d_color_errs", i), cerr, 0);
    end
    tick;
    check($sformatf("v%0d_done_once", i), bus.done, 0);
    check($sformatf("v%0d_busy_after", i), bus.busy, 0);
  endtask
  initial begin
    int t, seen, n0, d0, oerr;
    logic [15:0] exp_q[$];
    tbl[0]  = '{2'b00, 8'd10,  8'd20,  9'd0,   9'd0,   24'h0000FF, 1,     8'd10,  8'd20,  8'd10,  8'd20};
    tbl[1]  = '{2'b01, 8'd198, 8'd148, 9'd5,   9'd4,   24'h123456, 4,     8'd198, 8'd148, 8'd199, 8'd149};
    tbl[2]  = '{2'b10, 8'd7,   8'd9,   9'd0,   9'd0,   24'h000000, 30000, 8'd0,   8'd0,   8'd199, 8'd149};
    tbl[3]  = '{2'b01, 8'd5,   8'd5,   9'd0,   9'd3,   24'hFFFFFF, 0,     8'd0,   8'd0,   8'd0,   8'd0};
    tbl[4]  = '{2'b00, 8'd200, 8'd0,   9'd0,   9'd0,   24'h00FFFF, 0,     8'd0,   8'd0,   8'd0,   8'd0};
    tbl[5]  = '{2'b01, 8'd3,   8'd4,   9'd3,   9'd2,   24'hABCDEF, 6,     8'd3,   8'd4,   8'd5,   8'd5};
    tbl[6]  = '{2'b11, 8'd1,   8'd1,   9'd1,   9'd1,   24'h777777, 0,     8'd0,   8'd0,   8'd0,   8'd0};
    tbl[7]  = '{2'b01, 8'd10,  8'd149, 9'd300, 9'd300, 24'h00FF00, 190,   8'd10,  8'd149, 8'd199, 8'd149};
    tbl[8]  = '{2'b00, 8'd199, 8'd149, 9'd0,   9'd0,   24'hFF0000, 1,     8'd199, 8'd149, 8'd199, 8'd149};
    tbl[9]  = '{2'b01, 8'd0,   8'd150, 9'd5,   9'd5,   24'h010203, 0,     8'd0,   8'd0,   8'd0,   8'd0};
    tbl[10] = '{2'b01, 8'd250, 8'd0,   9'd511, 9'd1,   24'h040506, 0,     8'd0,   8'd0,   8'd0,   8'd0};
    tbl[11] = '{2'b01, 8'd100, 8'd0,   9'd511, 9'd1,   24'h0F0F0F, 100,   8'd100, 8'd0,   8'd199, 8'd0};
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_x0 = '0;
    bus.cmd_y0 = '0;
    bus.cmd_w = '0;
    bus.cmd_h = '0;
    bus.cmd_color = '0;
    repeat (3) tick;
    check("rst_fb_enable", bus.fb_enable, 0);
    check("rst_xy_addr", bus.xy_addr, 0);
    check("rst_color", bus.color, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);
    wq.delete();
    dn = 0;
    send(2'b01, 8'd20, 8'd30, 9'd10, 9'd10, 24'h111111);
    for (int k = 0; k < 4; k++) send(2'b01, 8'(50 + 4 * k), 8'd60, 9'd2, 9'd2, 24'(k + 1));
    check("b2b_full_ready", bus.cmd_ready, 0);
    check("b2b_full_busy", bus.busy, 1);
    send(2'b01, 8'd66, 8'd60, 9'd2, 9'd2, 24'h5);
    t = 0;
    while (bus.busy && t < 2000) begin
      tick;
      t++;
    end
    check("b2b_drain_busy", bus.busy, 0);
    for (int y = 30; y < 40; y++)
      for (int x = 20; x < 30; x++) exp_q.push_back({8'(y), 8'(x)});
    for (int k = 0; k < 5; k++)
      for (int y = 60; y < 62; y++)
        for (int x = 0; x < 2; x++) exp_q.push_back({8'(y), 8'(50 + 4 * k + x)});
    check("b2b_writes", wq.size(), 120);
    check("b2b_dones", dn, 6);
    oerr = 0;
    for (int j = 0; j < 120; j++) if (j >= wq.size() || wq[j] !== exp_q[j]) oerr++;
    check("b2b_order_errs", oerr, 0);
    send(2'b01, 8'd0, 8'd0, 9'd4, 9'd4, 24'hC0FFEE);
    send(2'b00, 8'd1, 8'd1, 9'd0, 9'd0, 24'h1);
    send(2'b00, 8'd2, 8'd2, 9'd0, 9'd0, 24'h2);
    seen = 0;
    t = 0;
    while (t < 50) begin
      if (bus.fb_enable) seen++;
      if (seen == 3) break;
      tick;
      t++;
    end
    check("rstmid_third_write", seen, 3);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    check("rstmid_fb_enable", bus.fb_enable, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_cmd_ready", bus.cmd_ready, 1);
    check("rstmid_done", bus.done, 0);
    check("rstmid_xy_addr", bus.xy_addr, 0);
    n0 = wq.size();
    d0 = dn;
    repeat (30) tick;
    check("rstmid_no_writes", wq.size(), n0);
    check("rstmid_no_done", dn, d0);
    check("rstmid_idle_busy", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
